// File: rtl/fifo_rd_arbiter.sv
// ---------------------------------------------------------------------------
// fifo_rd_arbiter
// Round-robin scheduler that shares the read port of an async FIFO among
// NREQ consumers in the read clock domain. One consumer at a time owns the
// port for a burst of up to BURST_LEN words. Each popped word is captured
// into a single-entry output buffer and tagged with the owner's index.
//
// Optional feature macro: FIFO_RD_ARB_EMPTY_RELEASE_EN
//   When defined, a burst that has popped at least one word and then sees
//   the FIFO empty gives the port up rather than waiting for more data.
//
// Ports:
//   rclk       in   read-domain clock
//   rrst_n     in   asynchronous active-low reset
//   rempty     in   FIFO empty flag (registered in the read-pointer logic)
//   rdata      in   FIFO word at the current read address
//   rinc       out  pop strobe to the FIFO (combinational)
//   req        in   per-consumer request (level)
//   out_ready  in   per-consumer accept
//   gnt        out  one-hot registered grant
//   out_data   out  buffered word
//   out_valid  out  out_data holds a word
//   out_id     out  index of the consumer owning out_data
// ---------------------------------------------------------------------------
module fifo_rd_arbiter #(
  parameter  int DSIZE     = 8,
  parameter  int NREQ      = 4,
  parameter  int BURST_LEN = 4,
  localparam int IDW       = $clog2(NREQ),
  localparam int CW        = $clog2(BURST_LEN + 1)
) (
  input  logic             rclk,
  input  logic             rrst_n,
  input  logic             rempty,
  input  logic [DSIZE-1:0] rdata,
  output logic             rinc,
  input  logic [NREQ-1:0]  req,
  input  logic [NREQ-1:0]  out_ready,
  output logic [NREQ-1:0]  gnt,
  output logic [DSIZE-1:0] out_data,
  output logic             out_valid,
  output logic [IDW-1:0]   out_id
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BURST = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [NREQ-1:0]  r_gnt;
  logic [IDW-1:0]   r_gidx;
  logic [IDW-1:0]   r_last;
  logic [CW-1:0]    r_count;
  logic [DSIZE-1:0] r_out_data;
  logic             r_out_valid;
  logic [IDW-1:0]   r_out_id;

  logic             w_sel_found;
  logic [IDW-1:0]   w_sel_idx;
  logic [NREQ-1:0]  w_sel_onehot;
  logic             w_accept;
  logic             w_pop;
  logic             w_grant;
  logic             w_release;

  // Round-robin search: first requester starting just after the last owner
  always_comb begin
    int             cand;
    logic [IDW-1:0] cidx;
    w_sel_found = 1'b0;
    w_sel_idx   = '0;
    cand        = 0;
    cidx        = '0;
    for (int i = 1; i <= NREQ; i++) begin
      cand = int'(r_last) + i;
      cand = (cand >= NREQ) ? (cand - NREQ) : cand;
      cidx = IDW'(cand);
      if (!w_sel_found && req[cidx]) begin
        w_sel_found = 1'b1;
        w_sel_idx   = cidx;
      end else begin
        w_sel_idx   = w_sel_idx;
      end
    end
  end

  assign w_sel_onehot = NREQ'(1'b1) << w_sel_idx;

  // Only the current owner's ready can free the buffer.
  assign w_accept = r_out_valid & out_ready[r_out_id];

  // A pop needs room in the buffer now or after this cycle's accept.
  assign w_pop = (r_state == ST_BURST) && req[r_gidx] && !rempty &&
                 (r_count < CW'(BURST_LEN)) && (!r_out_valid || w_accept);

  assign rinc = w_pop;

  // Next-state and grant/release decode
  always_comb begin
    w_state_nxt = r_state;
    w_grant     = 1'b0;
    w_release   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_sel_found) begin
          w_state_nxt = ST_BURST;
          w_grant     = 1'b1;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_BURST: begin
        // Leave when this pop is the last beat or the owner stops asking.
        if ((w_pop && (r_count == CW'(BURST_LEN - 1))) || !req[r_gidx]) begin
          w_state_nxt = ST_DRAIN;
`ifdef FIFO_RD_ARB_EMPTY_RELEASE_EN
        end else if ((r_count != '0) && rempty) begin
          w_state_nxt = ST_DRAIN;
`endif
        end else begin
          w_state_nxt = ST_BURST;
        end
      end
      ST_DRAIN: begin
        // Hold the grant until the owner's last word has left the buffer.
        if (!r_out_valid || w_accept) begin
          w_state_nxt = ST_IDLE;
          w_release   = 1'b1;
        end else begin
          w_state_nxt = ST_DRAIN;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // State, grant, round-robin pointer and beat counter registers
  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      r_state <= ST_IDLE;
      r_gnt   <= '0;
      r_gidx  <= '0;
      r_last  <= IDW'(NREQ - 1);
      r_count <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_grant) begin
        r_gnt   <= w_sel_onehot;
        r_gidx  <= w_sel_idx;
        r_count <= '0;
      end else if (w_release) begin
        r_gnt   <= '0;
        r_last  <= r_gidx;
      end else if (w_pop) begin
        r_count <= r_count + CW'(1);
      end
    end
  end

  // Single-entry output buffer tagged with the owner index
  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_out_id    <= '0;
    end else if (w_pop) begin
      r_out_data  <= rdata;
      r_out_id    <= r_gidx;
      r_out_valid <= 1'b1;
    end else if (w_accept) begin
      r_out_valid <= 1'b0;
    end
  end

  assign gnt       = r_gnt;
  assign out_data  = r_out_data;
  assign out_valid = r_out_valid;
  assign out_id    = r_out_id;

endmodule

// File: tb/tb_fifo_rd_arbiter.sv
// ---------------------------------------------------------------------------
// tb_fifo_rd_arbiter
// Directed bench for fifo_rd_arbiter (NREQ=4, BURST_LEN=4, DSIZE=8).
// A simple FIFO model supplies rempty/rdata. Expected grants, pop counts per
// grant and delivered words are queued by the stimulus; a negedge monitor
// pops and compares them as the DUT presents grants and accepted words.
// Honours FIFO_RD_ARB_EMPTY_RELEASE_EN for the empty-during-burst scenario.
// ---------------------------------------------------------------------------
module tb_fifo_rd_arbiter;

  localparam int DSIZE     = 8;
  localparam int NREQ      = 4;
  localparam int BURST_LEN = 4;

  logic             rclk = 1'b0;
  logic             rrst_n;
  logic             rempty;
  logic [DSIZE-1:0] rdata;
  logic             rinc;
  logic [NREQ-1:0]  req;
  logic [NREQ-1:0]  out_ready;
  logic [NREQ-1:0]  gnt;
  logic [DSIZE-1:0] out_data;
  logic             out_valid;
  logic [1:0]       out_id;

  logic [7:0] mem [0:255];
  int rptr = 0;
  int wptr = 0;

  int checks = 0;
  int errors = 0;

  logic [3:0] exp_gnt[$];
  int         exp_pops[$];
  int         exp_words[$];   // {id[1:0], data[7:0]}

  logic [3:0] prev_gnt = 4'd0;
  int         pops_cnt = 0;
  int         e_val;

  assign rempty = (rptr == wptr);
  assign rdata  = mem[rptr[7:0]];

  always #5 rclk = ~rclk;

  // FIFO read pointer advances on each pop
  always @(posedge rclk) begin
    if (rinc) rptr <= rptr + 1;
  end

  fifo_rd_arbiter #(
    .DSIZE(DSIZE), .NREQ(NREQ), .BURST_LEN(BURST_LEN)
  ) dut (
    .rclk(rclk), .rrst_n(rrst_n), .rempty(rempty), .rdata(rdata),
    .rinc(rinc), .req(req), .out_ready(out_ready), .gnt(gnt),
    .out_data(out_data), .out_valid(out_valid), .out_id(out_id)
  );

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Monitor: grant starts, pops per grant, accepted words
  always @(negedge rclk) begin
    if (gnt != 4'd0 && prev_gnt == 4'd0) begin
      e_val = (exp_gnt.size() > 0) ? int'(exp_gnt.pop_front()) : 0;
      check("grant", int'(gnt), e_val);
    end
    if (rinc) begin
      check("rinc_needs_gnt", int'(gnt != 4'd0), 1);
      pops_cnt++;
    end
    if (gnt == 4'd0 && prev_gnt != 4'd0) begin
      e_val = (exp_pops.size() > 0) ? exp_pops.pop_front() : -1;
      check("pops_per_grant", pops_cnt, e_val);
      pops_cnt = 0;
    end
    if (out_valid && out_ready[out_id]) begin
      e_val = (exp_words.size() > 0) ? exp_words.pop_front() : -1;
      check("word_id_data", int'({out_id, out_data}), e_val);
    end
    prev_gnt = gnt;
  end

  task automatic step();
    @(posedge rclk);
    #1;
  endtask

  task automatic push_word(input logic [7:0] d);
    mem[wptr[7:0]] = d;
    wptr++;
  endtask

  task automatic exp_grant(input logic [3:0] g, input int n);
    exp_gnt.push_back(g);
    exp_pops.push_back(n);
  endtask

  task automatic exp_data(input int id, input int first, input int n);
    for (int i = 0; i < n; i++) begin
      exp_words.push_back((id << 8) | ((first + i) & 255));
    end
  endtask

  task automatic wait_rptr(input int target, input string name);
    int k = 0;
    while (rptr < target && k < 200) begin
      step();
      k++;
    end
    check(name, int'(rptr >= target), 1);
  endtask

  task automatic wait_gnt_zero(input string name);
    int k = 0;
    while (gnt != 4'd0 && k < 200) begin
      step();
      k++;
    end
    check(name, int'(gnt), 0);
  endtask

  // Let the FIFO run dry, then withdraw requests and wait for the release
  task automatic finish_grant(input string name);
    wait_rptr(wptr, {name, "_drain_timeout"});
    req = 4'b0000;
    wait_gnt_zero({name, "_release_timeout"});
    step();
  endtask

  task automatic do_reset();
    rrst_n = 1'b0;
    step();
    step();
    rrst_n = 1'b1;
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int s;
    rrst_n    = 1'b0;
    req       = 4'b0000;
    out_ready = 4'b1111;
    step();
    step();
    rrst_n = 1'b1;
    step();

    // Reset state
    check("rst_gnt", int'(gnt), 0);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_out_data", int'(out_data), 0);
    check("rst_out_id", int'(out_id), 0);
    check("rst_rinc", int'(rinc), 0);

    // Single requester, 8 words: two bursts of 4, regranted
    for (int i = 0; i < 8; i++) push_word(8'(8'h10 + i));
    exp_grant(4'b0001, 4);
    exp_data(0, 8'h10, 4);
    exp_grant(4'b0001, 4);
    exp_data(0, 8'h14, 4);
    req = 4'b0001;
    check("t1_gnt_before_edge", int'(gnt), 0);
    step();
    check("t1_gnt_after_edge", int'(gnt), 1);
    finish_grant("t1");

    // All requesting, FIFO full enough: order 0,1,2,3,0 with wrap
    do_reset();
    for (int i = 0; i < 20; i++) push_word(8'(8'h20 + i));
    exp_grant(4'b0001, 4); exp_data(0, 8'h20, 4);
    exp_grant(4'b0010, 4); exp_data(1, 8'h24, 4);
    exp_grant(4'b0100, 4); exp_data(2, 8'h28, 4);
    exp_grant(4'b1000, 4); exp_data(3, 8'h2C, 4);
    exp_grant(4'b0001, 4); exp_data(0, 8'h30, 4);
    req = 4'b1111;
    finish_grant("t2");

    // Owner 2 stalls out_ready for 3 cycles; non-owner ready toggles
    do_reset();
    for (int i = 0; i < 4; i++) push_word(8'(8'h40 + i));
    exp_grant(4'b0100, 4);
    exp_data(2, 8'h40, 4);
    out_ready = 4'b1011;
    req       = 4'b0100;
    begin
      int k = 0;
      while (!out_valid && k < 50) begin
        step();
        k++;
      end
    end
    check("t3_first_valid", int'(out_valid), 1);
    for (int i = 0; i < 3; i++) begin
      check("t3_hold_valid", int'(out_valid), 1);
      check("t3_hold_data", int'(out_data), 8'h40);
      check("t3_hold_id", int'(out_id), 2);
      check("t3_no_rinc", int'(rinc), 0);
      out_ready[1] = ~out_ready[1];
      step();
    end
    out_ready = 4'b1111;
    finish_grant("t3");

    // Requester 1 drops after two beats; next search starts at 2
    do_reset();
    for (int i = 0; i < 4; i++) push_word(8'(8'h50 + i));
    exp_grant(4'b0010, 2);
    exp_data(1, 8'h50, 2);
    exp_grant(4'b0100, 2);
    exp_data(2, 8'h52, 2);
    s   = rptr;
    req = 4'b0010;
    wait_rptr(s + 2, "t4_two_beats");
    req = 4'b0000;
    wait_gnt_zero("t4_release");
    step();
    req = 4'b0111;
    finish_grant("t4");

    // FIFO empties after one beat of the burst
    do_reset();
    push_word(8'h60);
`ifdef FIFO_RD_ARB_EMPTY_RELEASE_EN
    exp_grant(4'b0001, 1);
    exp_grant(4'b0001, 3);
`else
    exp_grant(4'b0001, 4);
`endif
    exp_data(0, 8'h60, 4);
    s   = rptr;
    req = 4'b0001;
    wait_rptr(s + 1, "t5_first_beat");
    for (int i = 0; i < 4; i++) begin
`ifndef FIFO_RD_ARB_EMPTY_RELEASE_EN
      check("t5_gnt_held", int'(gnt), 1);
      check("t5_no_rinc", int'(rinc), 0);
`endif
      step();
    end
    for (int i = 1; i < 4; i++) push_word(8'(8'h60 + i));
    finish_grant("t5");

    // Reset mid-burst with a word buffered
    do_reset();
    for (int i = 0; i < 8; i++) push_word(8'(8'h70 + i));
    exp_grant(4'b0100, 2);
    exp_data(2, 8'h70, 1);
    s   = rptr;
    req = 4'b0100;
    wait_rptr(s + 2, "t6_two_beats");
    check("t6_valid_before_rst", int'(out_valid), 1);
    rrst_n = 1'b0;
    #1;
    check("t6_rst_gnt", int'(gnt), 0);
    check("t6_rst_out_valid", int'(out_valid), 0);
    check("t6_rst_out_data", int'(out_data), 0);
    check("t6_rst_out_id", int'(out_id), 0);
    exp_grant(4'b0010, 4);
    exp_data(1, 8'h72, 4);
    exp_grant(4'b0100, 2);
    exp_data(2, 8'h76, 2);
    req = 4'b0110;
    step();
    step();
    rrst_n = 1'b1;
    finish_grant("t6");

    step();
    step();
    check("left_grants", exp_gnt.size(), 0);
    check("left_pop_counts", exp_pops.size(), 0);
    check("left_words", exp_words.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fifo_rd_arbiter.md
Name: fifo_rd_arbiter

Overview:
- Round-robin scheduler sharing the read port of the async FIFO among NREQ consumers in the read clock domain.
- Grants the port to one consumer at a time for a burst of up to BURST_LEN words.
- Drives rinc into the read-pointer/empty logic and registers each popped word into a single-entry output buffer tagged with the owner ID.

Parameters:
- DSIZE, 8, FIFO data width.
- NREQ, 4, number of consumers (>=2).
- BURST_LEN, 4, maximum words popped per grant (>=1).

Ports:
- rclk  in  1  read-domain clock.
- rrst_n  in  1  reset; asynchronous assert, active-low.
- rempty  in  1  FIFO empty flag, registered, from read-pointer logic.
- rdata  in  DSIZE  FIFO read data at current raddr (combinational memory read).
- rinc  out  1  pop strobe to FIFO (combinational).
- req  in  NREQ  per-consumer request, level.
- out_ready  in  NREQ  per-consumer accept.
- gnt  out  NREQ  one-hot registered grant.
- out_data  out  DSIZE  buffered word.
- out_valid  out  1  out_data valid.
- out_id  out  clog2(NREQ)  consumer owning out_data.

Behaviour:
- Reset values: state IDLE, gnt=0, out_valid=0, out_data=0, out_id=0, beat count=0, last-grant pointer=NREQ-1 (so req[0] wins first).
- Reset mid-burst discards the buffered word and the burst count immediately.
- States: IDLE, BURST, DRAIN.
- IDLE:
  - If req!=0, select the first set bit searching upward from last+1, modulo NREQ.
  - Next cycle: gnt one-hot = selected, count=0, state=BURST.
  - If req==0, hold.
- Pop condition, combinational; rinc is 1 only when all of the following hold:
  - state==BURST.
  - req[g]=1, where g is the granted index.
  - rempty=0.
  - count<BURST_LEN.
  - out_valid=0, or out_ready[out_id]=1.
- On a pop edge:
  - out_data<=rdata, out_id<=g, out_valid<=1.
  - count<=count+1.
  - Latency: word popped at edge T is visible on out_data after T.
- Output buffer:
  - out_valid clears on out_ready[out_id]=1 without a simultaneous pop.
  - Pop and accept in the same cycle gives back-to-back transfer with out_valid staying 1.
  - out_ready bits of non-owners are ignored.
- BURST exit to DRAIN on the edge where either:
  - count reaches BURST_LEN after the pop, or
  - req[g]=0.
- BURST while rempty=1: hold in BURST waiting for data (unless EMPTY_RELEASE_EN).
- DRAIN:
  - gnt stays set and no pops occur.
  - When out_valid=0, or out_ready[out_id]=1 this cycle: gnt<=0, last<=g, state=IDLE.
  - Minimum one IDLE cycle between grants.
- Count width is clog2(BURST_LEN+1); count never exceeds BURST_LEN.
- req changes for non-granted consumers have no effect during BURST/DRAIN.
- Wrap: search order wraps from NREQ-1 to 0; a single persistent requester is regranted every burst.

Optional Feature:
- Macro: FIFO_RD_ARB_EMPTY_RELEASE_EN.
- Defined: in BURST with count>=1 and rempty=1, go to DRAIN next edge, releasing the port to other consumers.
- Not defined: the grant waits on empty until BURST_LEN words are popped or req[g] drops.

Test Plan:
- Reset, FIFO holds 8 words, req=0001, out_ready=1111, BURST_LEN=4:
  - gnt=0001 one cycle after req.
  - rinc high for 4 consecutive cycles, then DRAIN and IDLE.
  - Regrant gives 4 more words, each with out_id=0, in FIFO order.
- req=1111, FIFO never empty, out_ready all 1:
  - Grant order is 0,1,2,3,0.
  - Each grant pops exactly 4 words.
  - No rinc in DRAIN/IDLE cycles.
- Granted consumer 2 holds out_ready[2]=0 for 3 cycles:
  - out_valid stays 1 with out_data stable.
  - rinc=0 until ready.
  - A toggling out_ready[1] has no effect.
- req[1] drops after the 2nd beat: exactly 2 pops, then DRAIN, then IDLE, with last=1.
- FIFO empties after 1 beat of the burst:
  - Without the macro: rinc stays 0 and gnt holds until new data arrives, then the burst completes its 4 beats.
  - With the macro: DRAIN on the next edge.
- Assert rrst_n low mid-burst with out_valid=1:
  - Immediately gnt=0, out_valid=0, out_data=0.
  - After release, first grant goes to the lowest requesting index.
